// File: rtl/beta_exe_lsu_if.sv
// Data-memory bus between the exe-stage LSU (master) and data memory (slave).
// Address phase completes on req & gnt; one rvalid response per access.
// Backpressure: gnt stalls the address phase, rvalid stalls the response.
interface beta_exe_lsu_if #(
    parameter int DataWidth = 32
);
    logic                 data_req;
    logic                 data_gnt;
    logic [DataWidth-1:0] data_addr;
    logic                 data_we;
    logic [3:0]           data_be;
    logic [DataWidth-1:0] data_wdata;
    logic                 data_rvalid;
    logic [DataWidth-1:0] data_rdata;

    modport master (
        output data_req, data_addr, data_we, data_be, data_wdata,
        input  data_gnt, data_rvalid, data_rdata
    );

    modport slave (
        input  data_req, data_addr, data_we, data_be, data_wdata,
        output data_gnt, data_rvalid, data_rdata
    );
endinterface

// File: rtl/beta_exe_lsu.sv
// Exe-stage load/store unit: one aligned data access per CU request, formatted load result.
// Latency: 3 cycles en-to-idle with immediate gnt/rvalid; misaligned requests take 2.
// Backpressure: busy holds the CU; each low-gnt or missing-rvalid cycle adds one cycle.
module beta_exe_lsu #(
    parameter int DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 lsu_en_i,
    input  logic                 lsu_op_i,
    input  logic [1:0]           lsu_op_size_i,
    input  logic                 lsu_unsigned_i,
    input  logic [DataWidth-1:0] lsu_addr_i,
    input  logic [DataWidth-1:0] lsu_wdata_i,
    output logic                 lsu_busy_o,
    output logic [DataWidth-1:0] lsu_rdata_o,
    output logic                 lsu_err_o,
    beta_exe_lsu_if.master       data_bus
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_e;

    state_e               state_q, state_d;
    logic                 op_q;
    logic [1:0]           size_q;
    logic                 uns_q;
    logic [DataWidth-1:0] addr_q;
    logic [3:0]           be_q, be_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;
    logic [DataWidth-1:0] rdata_q, rdata_d;
    logic [DataWidth-1:0] shifted;
    logic                 misaligned;
    logic                 accept;
    logic                 load_done;

    assign misaligned = (lsu_op_size_i == 2'b11) ||
                        (lsu_op_size_i == 2'b01 && lsu_addr_i[0]) ||
                        (lsu_op_size_i == 2'b10 && lsu_addr_i[1:0] != 2'b00);
    assign accept     = (state_q == IDLE) && lsu_en_i;
    assign load_done  = (state_q == RESP) && data_bus.data_rvalid && !op_q;

    // Lane steering is computed from the live inputs so it can be captured with the request.
    always_comb begin
        be_d    = 4'b0000;
        wdata_d = lsu_wdata_i;
        case (lsu_op_size_i)
            2'b00: begin
                be_d    = 4'b0001 << lsu_addr_i[1:0];
                wdata_d = {4{lsu_wdata_i[7:0]}};
            end
            2'b01: begin
                be_d    = 4'b0011 << lsu_addr_i[1:0];
                wdata_d = {2{lsu_wdata_i[15:0]}};
            end
            2'b10:   be_d = 4'b1111;
            default: be_d = 4'b0000;
        endcase
    end

    assign shifted = data_bus.data_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        rdata_d = data_bus.data_rdata;
        case (size_q)
            2'b00: rdata_d = uns_q ? {{(DataWidth-8){1'b0}}, shifted[7:0]}
                                   : {{(DataWidth-8){shifted[7]}}, shifted[7:0]};
            2'b01: rdata_d = uns_q ? {{(DataWidth-16){1'b0}}, shifted[15:0]}
                                   : {{(DataWidth-16){shifted[15]}}, shifted[15:0]};
            default: rdata_d = data_bus.data_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (lsu_en_i) state_d = misaligned ? ERR : REQ;
            REQ:  if (data_bus.data_gnt) state_d = RESP;
            RESP: if (data_bus.data_rvalid) state_d = IDLE;
            ERR:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            op_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            be_q    <= 4'b0000;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q    <= lsu_op_i;
                size_q  <= lsu_op_size_i;
                uns_q   <= lsu_unsigned_i;
                addr_q  <= lsu_addr_i;
                be_q    <= be_d;
                wdata_q <= wdata_d;
            end
            if (load_done) rdata_q <= rdata_d;
        end
    end

    assign lsu_busy_o          = (state_q != IDLE);
    assign lsu_err_o           = (state_q == ERR);
    assign lsu_rdata_o         = rdata_q;
    assign data_bus.data_req   = (state_q == REQ);
    // we is qualified by REQ so an erroring store never shows a write on the bus.
    assign data_bus.data_we    = op_q && (state_q == REQ);
    assign data_bus.data_addr  = {addr_q[DataWidth-1:2], 2'b00};
    assign data_bus.data_be    = be_q;
    assign data_bus.data_wdata = wdata_q;
endmodule

// File: tb/tb_beta_exe_lsu.sv
// Directed bench for beta_exe_lsu: loads, stores, stalls, misalignment, reset mid-access.
module tb_beta_exe_lsu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        op = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        uns = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        busy;
    logic [31:0] rdata;
    logic        err;

    int n_cmp  = 0;
    int n_fail = 0;

    beta_exe_lsu_if #(.DataWidth(32)) bus ();

    beta_exe_lsu #(.DataWidth(32)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .lsu_en_i       (en),
        .lsu_op_i       (op),
        .lsu_op_size_i  (size),
        .lsu_unsigned_i (uns),
        .lsu_addr_i     (addr),
        .lsu_wdata_i    (wdata),
        .lsu_busy_o     (busy),
        .lsu_rdata_o    (rdata),
        .lsu_err_o      (err),
        .data_bus       (bus.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // CU-protocol model: raise en, drop it once busy is seen, wait for busy to fall.
    // The memory model grants whenever req is up and answers the cycle after.
    task automatic cu_op(input logic o, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] mem_rd,
                         output int rises);
        logic prev_busy;
        logic done;
        prev_busy = busy;
        done = 1'b0;
        rises = 0;
        op = o; size = sz; uns = 1'b0; addr = a; wdata = wd; en = 1'b1;
        for (int c = 0; c < 20 && !done; c++) begin
            tick();
            if (busy && !prev_busy) rises++;
            if (busy) en = 1'b0;
            if (!busy && prev_busy) done = 1'b1;
            prev_busy = busy;
            bus.data_gnt    = bus.data_req;
            bus.data_rvalid = busy && !bus.data_req;
            bus.data_rdata  = mem_rd;
        end
        check("cu_op_timeout", {31'd0, done}, 32'd1);
        en = 1'b0;
        bus.data_gnt = 1'b0;
        bus.data_rvalid = 1'b0;
    endtask

    initial begin
        int r1, r2;
        bus.data_gnt    = 1'b0;
        bus.data_rvalid = 1'b0;
        bus.data_rdata  = '0;

        // Reset state
        tick(); tick();
        rst = 1'b0;
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_req",   {31'd0, bus.data_req}, 32'd0);
        check("rst_we",    {31'd0, bus.data_we}, 32'd0);
        check("rst_err",   {31'd0, err}, 32'd0);
        check("rst_be",    {28'd0, bus.data_be}, 32'd0);
        check("rst_addr",  bus.data_addr, 32'd0);
        check("rst_wdata", bus.data_wdata, 32'd0);
        check("rst_rdata", rdata, 32'd0);

        // LB signed at 0x1003, immediate gnt/rvalid
        op = 1'b0; size = 2'b00; uns = 1'b0; addr = 32'h0000_1003; en = 1'b1;
        bus.data_gnt = 1'b1;
        tick();
        check("lb_c1_busy", {31'd0, busy}, 32'd1);
        check("lb_c1_req",  {31'd0, bus.data_req}, 32'd1);
        check("lb_c1_be",   {28'd0, bus.data_be}, 32'h8);
        check("lb_c1_addr", bus.data_addr, 32'h0000_1000);
        check("lb_c1_we",   {31'd0, bus.data_we}, 32'd0);
        en = 1'b0;
        bus.data_rvalid = 1'b1; bus.data_rdata = 32'h80FF_1234;
        tick();
        bus.data_gnt = 1'b0;
        check("lb_c2_busy", {31'd0, busy}, 32'd1);
        check("lb_c2_req",  {31'd0, bus.data_req}, 32'd0);
        tick();
        bus.data_rvalid = 1'b0;
        check("lb_c3_busy",  {31'd0, busy}, 32'd0);
        check("lb_c3_rdata", rdata, 32'hFFFF_FF80);

        // LHU at 0x2002, gnt held low 3 cycles
        op = 1'b0; size = 2'b01; uns = 1'b1; addr = 32'h0000_2002; en = 1'b1;
        tick();
        en = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            check("lhu_req",  {31'd0, bus.data_req}, 32'd1);
            check("lhu_addr", bus.data_addr, 32'h0000_2000);
            check("lhu_busy", {31'd0, busy}, 32'd1);
            if (c == 4) bus.data_gnt = 1'b1;
            tick();
        end
        bus.data_gnt = 1'b0;
        check("lhu_c5_busy", {31'd0, busy}, 32'd1);
        check("lhu_c5_req",  {31'd0, bus.data_req}, 32'd0);
        check("lhu_be",      {28'd0, bus.data_be}, 32'hC);
        bus.data_rvalid = 1'b1; bus.data_rdata = 32'hBEEF_0000;
        tick();
        bus.data_rvalid = 1'b0;
        check("lhu_c6_busy",  {31'd0, busy}, 32'd0);
        check("lhu_c6_rdata", rdata, 32'h0000_BEEF);

        // SB at 0x3001
        op = 1'b1; size = 2'b00; uns = 1'b0; addr = 32'h0000_3001; wdata = 32'h1234_56AB;
        en = 1'b1; bus.data_gnt = 1'b1;
        tick();
        en = 1'b0;
        check("sb_we",    {31'd0, bus.data_we}, 32'd1);
        check("sb_be",    {28'd0, bus.data_be}, 32'h2);
        check("sb_wdata", bus.data_wdata, 32'hABAB_ABAB);
        check("sb_addr",  bus.data_addr, 32'h0000_3000);
        tick();
        bus.data_gnt = 1'b0;
        bus.data_rvalid = 1'b1; bus.data_rdata = 32'hDEAD_DEAD;
        check("sb_c2_busy", {31'd0, busy}, 32'd1);
        tick();
        bus.data_rvalid = 1'b0;
        check("sb_c3_busy",  {31'd0, busy}, 32'd0);
        check("sb_c3_rdata", rdata, 32'h0000_BEEF);

        // LW at 0x4002: misaligned
        op = 1'b0; size = 2'b10; addr = 32'h0000_4002; en = 1'b1;
        tick();
        en = 1'b0;
        check("lw_mis_err",  {31'd0, err}, 32'd1);
        check("lw_mis_busy", {31'd0, busy}, 32'd1);
        check("lw_mis_req",  {31'd0, bus.data_req}, 32'd0);
        tick();
        check("lw_mis_err2",  {31'd0, err}, 32'd0);
        check("lw_mis_busy2", {31'd0, busy}, 32'd0);
        check("lw_mis_req2",  {31'd0, bus.data_req}, 32'd0);
        check("lw_mis_rdata", rdata, 32'h0000_BEEF);

        // Reset while in RESP, then a stray rvalid
        op = 1'b1; size = 2'b10; addr = 32'h0000_5000; wdata = 32'h5555_AAAA; en = 1'b1;
        bus.data_gnt = 1'b1;
        tick();
        en = 1'b0;
        tick();
        bus.data_gnt = 1'b0;
        check("rr_in_resp", {31'd0, busy && !bus.data_req}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rr_busy",  {31'd0, busy}, 32'd0);
        check("rr_addr",  bus.data_addr, 32'd0);
        check("rr_wdata", bus.data_wdata, 32'd0);
        check("rr_be",    {28'd0, bus.data_be}, 32'd0);
        check("rr_rdata", rdata, 32'd0);
        bus.data_rvalid = 1'b1; bus.data_rdata = 32'h1111_1111;
        tick();
        bus.data_rvalid = 1'b0;
        check("rr_stray_busy",  {31'd0, busy}, 32'd0);
        check("rr_stray_req",   {31'd0, bus.data_req}, 32'd0);
        check("rr_stray_rdata", rdata, 32'd0);

        // Back-to-back SW then LW through the CU protocol model
        cu_op(1'b1, 2'b10, 32'h0000_0010, 32'hCAFE_F00D, 32'h0000_0000, r1);
        cu_op(1'b0, 2'b10, 32'h0000_0010, 32'h0000_0000, 32'hCAFE_F00D, r2);
        check("b2b_pulses", r1 + r2, 32'd2);
        check("b2b_rdata",  rdata, 32'hCAFE_F00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
